// File: rtl/mips_cpu_bus_core.sv
// mips_cpu_bus_core: multi-cycle MIPS32 (little-endian, integer subset) core
// sharing one Avalon-style bus for instruction fetch and data access.
// Optional feature macro: MIPS_SUBWORD_MEM_EN adds lb/lbu/lh/lhu/sb/sh.
module mips_cpu_bus_core (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;     // address of the instruction in flight
    logic [31:0] npc_q, npc_d;   // next fetch address (carries the delay-slot redirect)
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;       // rs value
    logic [31:0] b_q, b_d;       // rt value
    logic [31:0] regs_q [32];
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic [5:0]  op, funct;
    logic [4:0]  rt_f, rd_f, shamt;
    logic [31:0] imm_s, imm_z, pc_plus4, br_target;
    assign op        = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign rt_f      = ir_q[20:16];
    assign rd_f      = ir_q[15:11];
    assign shamt     = ir_q[10:6];
    assign imm_s     = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_z     = {16'd0, ir_q[15:0]};
    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_s[29:0], 2'b00};
    assign register_v0 = regs_q[2];

    logic [31:0] alu_res, jmp_target;
    logic        alu_we, br_taken;
    logic [4:0]  alu_wa;

    // ALU result, destination register and branch/jump resolution for EXEC
    always_comb begin
        alu_res    = '0;
        alu_we     = 1'b0;
        alu_wa     = rt_f;
        br_taken   = 1'b0;
        jmp_target = br_target;
        case (op)
            6'h00: begin
                alu_we = 1'b1;
                alu_wa = rd_f;
                case (funct)
                    6'h00: alu_res = b_q << shamt;
                    6'h02: alu_res = b_q >> shamt;
                    6'h03: alu_res = 32'($signed(b_q) >>> shamt);
                    6'h04: alu_res = b_q << a_q[4:0];
                    6'h06: alu_res = b_q >> a_q[4:0];
                    6'h07: alu_res = 32'($signed(b_q) >>> a_q[4:0]);
                    6'h08: begin alu_we = 1'b0; br_taken = 1'b1; jmp_target = a_q; end
                    6'h09: begin alu_res = pc_q + 32'd8; br_taken = 1'b1; jmp_target = a_q; end
                    6'h21: alu_res = a_q + b_q;
                    6'h23: alu_res = a_q - b_q;
                    6'h24: alu_res = a_q & b_q;
                    6'h25: alu_res = a_q | b_q;
                    6'h26: alu_res = a_q ^ b_q;
                    6'h27: alu_res = ~(a_q | b_q);
                    6'h2A: alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
                    6'h2B: alu_res = {31'd0, a_q < b_q};
                    default: alu_we = 1'b0;
                endcase
            end
            6'h01: begin
                if (rt_f == 5'd0) br_taken = a_q[31];
                if (rt_f == 5'd1) br_taken = !a_q[31];
            end
            6'h02: begin br_taken = 1'b1; jmp_target = {pc_plus4[31:28], ir_q[25:0], 2'b00}; end
            6'h03: begin
                br_taken   = 1'b1;
                jmp_target = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                alu_we     = 1'b1;
                alu_wa     = 5'd31;
                alu_res    = pc_q + 32'd8;
            end
            6'h04: br_taken = (a_q == b_q);
            6'h05: br_taken = (a_q != b_q);
            6'h06: br_taken = a_q[31] || (a_q == 32'd0);
            6'h07: br_taken = !a_q[31] && (a_q != 32'd0);
            6'h09: begin alu_we = 1'b1; alu_res = a_q + imm_s; end
            6'h0A: begin alu_we = 1'b1; alu_res = {31'd0, $signed(a_q) < $signed(imm_s)}; end
            6'h0B: begin alu_we = 1'b1; alu_res = {31'd0, a_q < imm_s}; end
            6'h0C: begin alu_we = 1'b1; alu_res = a_q & imm_z; end
            6'h0D: begin alu_we = 1'b1; alu_res = a_q | imm_z; end
            6'h0E: begin alu_we = 1'b1; alu_res = a_q ^ imm_z; end
            6'h0F: begin alu_we = 1'b1; alu_res = {ir_q[15:0], 16'd0}; end
            default: ;
        endcase
    end

    logic        is_load, is_store;
    logic [31:0] ea, load_val, store_data;
    logic [3:0]  mem_be;
`ifdef MIPS_SUBWORD_MEM_EN
    logic [31:0] lane_data;
`endif

    // Memory access decode: effective address, lane enables, store data, load extraction
    always_comb begin
        ea         = a_q + imm_s;
        is_load    = (op == 6'h23);
        is_store   = (op == 6'h2B);
        mem_be     = 4'b1111;
        store_data = b_q;
        load_val   = readdata;
`ifdef MIPS_SUBWORD_MEM_EN
        lane_data  = readdata >> {ea[1:0], 3'b000};
        case (op)
            6'h20: begin is_load = 1'b1; mem_be = 4'b0001 << ea[1:0];
                         load_val = {{24{lane_data[7]}}, lane_data[7:0]}; end
            6'h24: begin is_load = 1'b1; mem_be = 4'b0001 << ea[1:0];
                         load_val = {24'd0, lane_data[7:0]}; end
            6'h21: begin is_load = 1'b1; mem_be = ea[1] ? 4'b1100 : 4'b0011;
                         load_val = {{16{lane_data[15]}}, lane_data[15:0]}; end
            6'h25: begin is_load = 1'b1; mem_be = ea[1] ? 4'b1100 : 4'b0011;
                         load_val = {16'd0, lane_data[15:0]}; end
            6'h28: begin is_store = 1'b1; mem_be = 4'b0001 << ea[1:0];
                         store_data = {4{b_q[7:0]}}; end
            6'h29: begin is_store = 1'b1; mem_be = ea[1] ? 4'b1100 : 4'b0011;
                         store_data = {2{b_q[15:0]}}; end
            default: ;
        endcase
`endif
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        rf_we   = 1'b0;
        rf_wa   = 5'd0;
        rf_wd   = '0;
        case (state_q)
            S_FETCH: begin
                if (pc_q == 32'd0)    state_d = S_HALT;
                else if (!waitrequest) state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = readdata;
                a_d     = regs_q[readdata[25:21]];
                b_d     = regs_q[readdata[20:16]];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                rf_we   = alu_we;
                rf_wa   = alu_wa;
                rf_wd   = alu_res;
                // The delay-slot instruction (npc) runs next; the redirect lands after it.
                pc_d    = npc_q;
                npc_d   = br_taken ? jmp_target : npc_q + 32'd4;
                state_d = (is_load || is_store) ? S_MEM : S_FETCH;
            end
            S_MEM: begin
                if (!waitrequest) state_d = is_load ? S_WB : S_FETCH;
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wa   = rt_f;
                rf_wd   = load_val;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Bus outputs decoded purely from state so they hold steady during a stall
    always_comb begin
        active     = (state_q != S_HALT);
        read       = 1'b0;
        write      = 1'b0;
        address    = pc_q;
        byteenable = 4'b1111;
        writedata  = b_q;
        case (state_q)
            S_FETCH: read = reset && (pc_q != 32'd0);
            S_MEM: begin
                address    = ea & 32'hFFFF_FFFC;
                byteenable = mem_be;
                writedata  = store_data;
                read       = reset && is_load;
                write      = reset && is_store;
            end
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            npc_q   <= RESET_VECTOR + 32'd4;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Register file: cleared on reset, $0 never written
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (rf_we && (rf_wa != 5'd0)) begin
            regs_q[rf_wa] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Directed testbench for mips_cpu_bus_core: small programs run from a
// bus-attached memory model with optional waitrequest stalls.
module tb_mips_cpu_bus_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        active, write, read, waitrequest;
    logic [31:0] register_v0, address, writedata, readdata;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_cpu_bus_core dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    // Memory model: 64 words at 0xBFC00000, fixed stall count per access
    logic [31:0] mem [0:63];
    int wait_cfg = 0;
    int wcnt = 0;
    assign waitrequest = (read || write) && (wcnt < wait_cfg);

    always @(posedge clk) begin
        if (!reset) begin
            wcnt <= 0;
        end else if (read || write) begin
            if (wcnt < wait_cfg) begin
                wcnt <= wcnt + 1;
            end else begin
                wcnt <= 0;
                if (read) readdata <= (address[31:8] == 24'hBFC000) ? mem[address[7:2]] : 32'h0;
                if (write && address[31:8] == 24'hBFC000)
                    for (int k = 0; k < 4; k++)
                        if (byteenable[k]) mem[address[7:2]][8*k +: 8] = writedata[8*k +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    typedef struct {
        logic [7:0][31:0] prog;
        logic [31:0]      dat_a;     // word 11 (0xBFC0002C)
        logic [31:0]      dat_b;     // word 12 (0xBFC00030)
        int               wait_n;
        logic             chk_store;
        logic [31:0]      exp_v0;
    } vec_t;

    vec_t vecs[13];

    // Bus monitor state shared by the run loop
    logic        hold, h_read, overlap, saw_wr;
    logic [31:0] h_addr, wr_addr, wr_data;
    logic [3:0]  wr_be;

    task automatic monitor();
        if (hold) begin
            check("stall_addr", address, h_addr);
            check("stall_read", {31'd0, read}, {31'd0, h_read});
        end
        hold   = waitrequest;
        h_addr = address;
        h_read = read;
        if (read && write) overlap = 1'b1;
        if (write && !waitrequest) begin
            saw_wr  = 1'b1;
            wr_addr = address;
            wr_be   = byteenable;
            wr_data = writedata;
        end
    endtask

    task automatic load_mem(input logic [7:0][31:0] prog, input logic [31:0] da, input logic [31:0] db);
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        for (int k = 0; k < 8; k++) mem[k] = prog[k];
        mem[11] = da;
        mem[12] = db;
    endtask

    task automatic run_vec(input int i);
        logic halted;
        reset    = 1'b0;
        wait_cfg = vecs[i].wait_n;
        load_mem(vecs[i].prog, vecs[i].dat_a, vecs[i].dat_b);
        @(negedge clk);
        @(negedge clk);
        check($sformatf("v%0d_rst_read", i), {31'd0, read}, 32'd0);
        check($sformatf("v%0d_rst_v0", i), register_v0, 32'd0);
        reset   = 1'b1;
        hold    = 1'b0;
        overlap = 1'b0;
        saw_wr  = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_active_up", i), {31'd0, active}, 32'd1);
        halted = 1'b0;
        for (int c = 0; c < 5000 && !halted; c++) begin
            if (!active) halted = 1'b1;
            else begin
                monitor();
                @(negedge clk);
            end
        end
        check($sformatf("v%0d_halted", i), {31'd0, halted}, 32'd1);
        check($sformatf("v%0d_v0", i), register_v0, vecs[i].exp_v0);
        check($sformatf("v%0d_rw_overlap", i), {31'd0, overlap}, 32'd0);
        if (vecs[i].chk_store) begin
            check($sformatf("v%0d_saw_write", i), {31'd0, saw_wr}, 32'd1);
            check($sformatf("v%0d_wr_be", i), {28'd0, wr_be}, 32'hF);
            check($sformatf("v%0d_wr_addr", i), wr_addr, 32'hBFC0_0040);
            check($sformatf("v%0d_wr_data", i), wr_data, 32'h1234_5678);
            check($sformatf("v%0d_mem16", i), mem[16], 32'h1234_5678);
        end
        $display("vector %0d: wait=%0d v0=%h expected=%h", i, vecs[i].wait_n, register_v0, vecs[i].exp_v0);
    endtask

    initial begin
        logic [31:0] lui8, lw9, lw10, jr0;
        logic [7:0][31:0] p;
        lui8 = enc_i(15, 0, 8, 16'hBFC0);
        lw9  = enc_i(35, 8, 9, 16'h002C);
        lw10 = enc_i(35, 8, 10, 16'h0030);
        jr0  = enc_r(0, 0, 0, 0, 8);
        for (int i = 0; i < 13; i++) begin
            vecs[i].prog = '0; vecs[i].dat_a = '0; vecs[i].dat_b = '0;
            vecs[i].wait_n = 0; vecs[i].chk_store = 1'b0; vecs[i].exp_v0 = '0;
        end
        // slt with delay slot: -2 < 10 signed
        vecs[0].prog[0] = lui8; vecs[0].prog[1] = lw9; vecs[0].prog[2] = lw10;
        vecs[0].prog[3] = jr0;  vecs[0].prog[4] = enc_r(10, 9, 2, 0, 42);
        vecs[0].dat_a = 32'd10; vecs[0].dat_b = 32'hFFFF_FFFE; vecs[0].exp_v0 = 32'd1;
        // sltu: 0xFFFFFFFE < 10 is false
        vecs[1] = vecs[0]; vecs[1].prog[4] = enc_r(10, 9, 2, 0, 43); vecs[1].exp_v0 = 32'd0;
        // addiu -1
        vecs[2].prog[0] = enc_i(9, 0, 2, 16'hFFFF); vecs[2].prog[1] = jr0; vecs[2].exp_v0 = 32'hFFFF_FFFF;
        // ori zero-extends
        vecs[3].prog[0] = enc_i(13, 0, 2, 16'h8000); vecs[3].prog[1] = jr0; vecs[3].exp_v0 = 32'h0000_8000;
        // store/load round trip through 0xBFC00040
        vecs[4].prog[0] = lui8; vecs[4].prog[1] = lw9;
        vecs[4].prog[2] = enc_i(43, 8, 9, 16'h0040); vecs[4].prog[3] = enc_i(35, 8, 2, 16'h0040);
        vecs[4].prog[4] = jr0; vecs[4].dat_a = 32'h1234_5678;
        vecs[4].chk_store = 1'b1; vecs[4].exp_v0 = 32'h1234_5678;
        // beq taken: delay slot runs, next instruction skipped
        vecs[5].prog[0] = enc_i(4, 0, 0, 16'h0002); vecs[5].prog[1] = enc_i(9, 0, 2, 16'd5);
        vecs[5].prog[2] = enc_i(9, 2, 2, 16'd1);    vecs[5].prog[3] = jr0; vecs[5].exp_v0 = 32'd5;
        // subu then xori in the jr delay slot: (0-7)^0xFF
        vecs[6].prog[0] = enc_i(9, 0, 3, 16'd7); vecs[6].prog[1] = enc_r(0, 3, 2, 0, 35);
        vecs[6].prog[2] = jr0; vecs[6].prog[3] = enc_i(14, 2, 2, 16'h00FF); vecs[6].exp_v0 = 32'hFFFF_FF06;
        // lui + sra keeps the sign
        vecs[7].prog[0] = enc_i(15, 0, 2, 16'h8000); vecs[7].prog[1] = enc_r(0, 2, 2, 4, 3);
        vecs[7].prog[2] = jr0; vecs[7].exp_v0 = 32'hF800_0000;
        // jal to word 4 links PC+8
        vecs[8].prog[0] = {6'd3, 26'h3F0_0004}; vecs[8].prog[4] = enc_r(31, 0, 2, 0, 33);
        vecs[8].prog[5] = jr0; vecs[8].exp_v0 = 32'hBFC0_0008;
        // bne not taken, sll in the following slot
        vecs[9].prog[0] = enc_i(9, 0, 2, 16'd3); vecs[9].prog[1] = enc_i(5, 2, 2, 16'd5);
        vecs[9].prog[2] = enc_r(0, 2, 2, 4, 0);  vecs[9].prog[3] = jr0; vecs[9].exp_v0 = 32'h30;
        // same programs with 3 stall cycles per access
        vecs[10] = vecs[0]; vecs[10].wait_n = 3;
        vecs[11] = vecs[4]; vecs[11].wait_n = 3;
        vecs[12] = vecs[5]; vecs[12].wait_n = 3;

        for (int i = 0; i < 13; i++) run_vec(i);

        // Reset mid-program: tight loop holding v0=9
        wait_cfg = 0;
        reset = 1'b0;
        p = '0;
        p[0] = enc_i(9, 0, 2, 16'd9);
        p[1] = enc_i(4, 0, 0, 16'hFFFF);
        load_mem(p, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_write", {31'd0, write}, 32'd0);
        reset = 1'b1;
        #1 check("first_fetch_read", {31'd0, read}, 32'd1);
        check("first_fetch_addr", address, 32'hBFC0_0000);
        @(negedge clk);
        @(negedge clk);
        check("alu_latency_before", register_v0, 32'd0);
        @(negedge clk);
        check("alu_latency_after", register_v0, 32'd9);
        repeat (60) @(negedge clk);
        check("loop_active", {31'd0, active}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_v0", register_v0, 32'd0);
        check("midrst_read", {31'd0, read}, 32'd0);
        reset = 1'b1;
        #1 check("restart_addr", address, 32'hBFC0_0000);
        check("restart_read", {31'd0, read}, 32'd1);
        repeat (20) @(negedge clk);
        check("restart_v0", register_v0, 32'd9);
        $display("reset sequence: v0=%h active=%0d", register_v0, active);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
